control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  in  1  system clock; all state changes on rising edge.
REQ-002 clear  in  1  synchronous, active-high reset.
REQ-003 IR  in  32  instruction register contents from datapath; opcode=IR[31:27].
REQ-004 MemDone  in  1  memory completion; high for the cycle in which a read or write finishes.
REQ-005 PCout  out  1  drive PC onto bus.
REQ-006 PCin  out  1  load PC from bus.
REQ-007 IncPC  out  1  ALU computes PC+1 into Z.
REQ-008 MARin  out  1  load MAR from bus.
REQ-009 MDRin  out  1  load MDR (from memory when Read=1, else from bus).
REQ-010 MDRout  out  1  drive MDR onto bus.
REQ-011 Read  out  1  memory read request, held until MemDone.
REQ-012 Write  out  1  memory write request, held until MemDone.
REQ-013 IRin  out  1  load IR from bus.
REQ-014 Yin  out  1  load Y from bus.
REQ-015 Zin  out  1  load Z from ALU.
REQ-016 Zlowout  out  1  drive Zlow onto bus.
REQ-017 Gr  out  3  one-hot register-field select {Grc,Grb,Gra}.
REQ-018 Rin / Rout / BAout  out  1 each  selected-register load / drive / base-address drive (R0 reads as 0).
REQ-019 Cout  out  1  drive sign-extended IR[18:0] onto bus.
REQ-020 AluOp  out  2  00 ADD, 01 SUB, 10 AND, 11 OR; meaningful only when Zin=1.
REQ-021 Run  out  1  high in every state except HALT.
REQ-022 Illegal  out  1  high while halted on an undefined opcode.

Function
REQ-023 Moore machine: all outputs SHALL decode from the registered state plus IR[31:27], and are asserted for exactly the cycle spent in that state.
REQ-024 States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT; any output not named for a state SHALL be 0.
REQ-025 RST: all outputs 0, Run=1; next state T0.
REQ-026 T0: PCout, MARin, IncPC, Zin -> T1.
REQ-027 T1: Zlowout, PCin, Read, MDRin; PCin only in the first T1 cycle; stay in T1 until MemDone=1 (MemDone in the first cycle means zero wait) -> T2.
REQ-028 T2: MDRout, IRin -> T3; the opcode is decoded from T3 onward.
REQ-029 add 00011 / sub 00100 / and 00101 / or 00110: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,AluOp per opcode; T5 Zlowout,Gra,Rin -> T0.
REQ-030 addi 01100: T3 Grb,Rout,Yin; T4 Cout,Zin,AluOp=ADD; T5 Zlowout,Gra,Rin -> T0.
REQ-031 ld 00000 / st 00010 address phase: T3 Grb,BAout,Yin; T4 Cout,Zin,ADD; T5 Zlowout,MARin -> T6.
REQ-032 ld: T6 Read,MDRin, wait for MemDone; T7 MDRout,Gra,Rin -> T0.
REQ-033 st: T6 Gra,Rout,MDRin; T7 Write, wait for MemDone -> T0.
REQ-034 halt 11011: T3 -> HALT; HALT holds all strobes 0 and Run=0 until clear.
REQ-035 Read and Write SHALL never be high together; a write SHALL start only after MDR has been loaded in T6.

Reset
REQ-036 clear=1 at any edge, including mid-wait in T1/T6/T7 or in HALT, SHALL force the state to RST, clear Illegal, and abandon the pending memory request.
REQ-037 The cycle after clear is released SHALL be T0; the first fetch is issued at the current PC.

Configuration
REQ-038 CU_ILLEGAL_TRAP_EN defined: an undefined opcode at T3 goes to HALT with Illegal=1. Undefined: treated as a no-op, T3 -> T0, and Illegal is tied to 0.

Structure
REQ-039 Package cu_pkg SHALL hold the state enum, the opcode constants, and the AluOp encodings.
REQ-040 Opcode classification (alu/imm/ld/st/halt/illegal) SHALL live in one combinational sub-module, cu_opdecode.

Verification
REQ-041 IR=add R1,R2,R3 (0x18918000), MemDone=1 every cycle -> T0..T5 in 6 cycles; T4 AluOp=00; T5 Gr=001 with Rin=1.
REQ-042 ld R4,0x10(R2), MemDone delayed 3 cycles in T6 -> Read and MDRin held for 4 cycles; Write never asserted; T7 Rin with Gra.
REQ-043 st with MemDone at the first T7 cycle -> Write high for exactly 1 cycle; Read=0 throughout T5-T7.
REQ-044 halt opcode -> Run falls at the cycle after T3 and stays 0 for 20 cycles; clear -> RST then T0 with PCout=1.
REQ-045 clear asserted during a T1 wait -> next state RST with Read=0; the fetch restarts at T0.
REQ-046 Opcode 11111 with CU_ILLEGAL_TRAP_EN -> HALT with Illegal=1; without the macro -> T0 after T3 and Illegal=0.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the control sequencer.
//   state_e      - sequencer states (RST, T0..T7, HALT)
//   Op*          - 5-bit opcode values found in IR[31:27]
//   alu_op_e     - ALU operation select driven with Zin
//   Gr*          - one-hot register-field selects {Grc, Grb, Gra}
//   op_class_t   - opcode classification produced by cu_opdecode
package cu_pkg;

    typedef enum logic [3:0] {
        StRst,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StT7,
        StHalt
    } state_e;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluOr  = 2'b11
    } alu_op_e;

    localparam logic [2:0] GrNone = 3'b000;
    localparam logic [2:0] GrA    = 3'b001;
    localparam logic [2:0] GrB    = 3'b010;
    localparam logic [2:0] GrC    = 3'b100;

    typedef struct packed {
        logic alu;
        logic imm;
        logic ld;
        logic st;
        logic halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/cu_if.sv
// cu_if: datapath <-> control sequencer signal bundle.
//   ir, mem_done           - datapath to sequencer (instruction, memory completion)
//   pc_out .. c_out        - single-bit control strobes to the datapath
//   gr                     - one-hot register-field select {Grc, Grb, Gra}
//   alu_op                 - ALU operation, meaningful only with z_in
//   run, illegal           - sequencer status
// master = sequencer side, slave = datapath side.
interface cu_if;
    logic [31:0] ir;
    logic        mem_done;
    logic        pc_out;
    logic        pc_in;
    logic        inc_pc;
    logic        mar_in;
    logic        mdr_in;
    logic        mdr_out;
    logic        read;
    logic        write;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        zlow_out;
    logic [2:0]  gr;
    logic        r_in;
    logic        r_out;
    logic        ba_out;
    logic        c_out;
    logic [1:0]  alu_op;
    logic        run;
    logic        illegal;

    modport master (
        input  ir, mem_done,
        output pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in,
               y_in, z_in, zlow_out, gr, r_in, r_out, ba_out, c_out, alu_op, run, illegal
    );

    modport slave (
        output ir, mem_done,
        input  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in,
               y_in, z_in, zlow_out, gr, r_in, r_out, ba_out, c_out, alu_op, run, illegal
    );
endinterface

// File: rtl/cu_opdecode.sv
// cu_opdecode: combinational opcode classifier.
//   opcode_i    - IR[31:27]
//   op_class_o  - one of alu/imm/ld/st/halt/illegal
//   alu_op_o    - ALU operation for register-register ops, ADD otherwise
module cu_opdecode
    import cu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_t  op_class_o,
    output alu_op_e    alu_op_o
);

    always_comb begin
        op_class_o = '0;
        alu_op_o   = AluAdd;
        case (opcode_i)
            OpAdd:   op_class_o.alu = 1'b1;
            OpSub:   begin op_class_o.alu = 1'b1; alu_op_o = AluSub; end
            OpAnd:   begin op_class_o.alu = 1'b1; alu_op_o = AluAnd; end
            OpOr:    begin op_class_o.alu = 1'b1; alu_op_o = AluOr;  end
            OpAddi:  op_class_o.imm  = 1'b1;
            OpLd:    op_class_o.ld   = 1'b1;
            OpSt:    op_class_o.st   = 1'b1;
            OpHalt:  op_class_o.halt = 1'b1;
            default: op_class_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit sequencing fetch and execute microsteps.
//   clock_i  - system clock, rising edge
//   clear_i  - synchronous active-high reset; abandons any pending memory request
//   bus      - cu_if.master: IR/MemDone in, control strobes, Run and Illegal out
// Build option: define CU_ILLEGAL_TRAP_EN to halt with Illegal=1 on undefined
// opcodes; otherwise they behave as no-ops and Illegal is tied to 0.
module control_sequencer
    import cu_pkg::*;
(
    input  logic clock_i,
    input  logic clear_i,
    cu_if.master bus
);

    state_e    state_q, state_d;
    logic      t1_wait_q;
    op_class_t op;
    alu_op_e   alu_op_dec;

    cu_opdecode u_opdecode (
        .opcode_i   (bus.ir[31:27]),
        .op_class_o (op),
        .alu_op_o   (alu_op_dec)
    );

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q   <= StRst;
            t1_wait_q <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            // Set from the second T1 cycle on, so PC is loaded only once per fetch.
            t1_wait_q <= (state_q == StT1);
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bus.pc_out   = 1'b0;
        bus.pc_in    = 1'b0;
        bus.inc_pc   = 1'b0;
        bus.mar_in   = 1'b0;
        bus.mdr_in   = 1'b0;
        bus.mdr_out  = 1'b0;
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.ir_in    = 1'b0;
        bus.y_in     = 1'b0;
        bus.z_in     = 1'b0;
        bus.zlow_out = 1'b0;
        bus.gr       = GrNone;
        bus.r_in     = 1'b0;
        bus.r_out    = 1'b0;
        bus.ba_out   = 1'b0;
        bus.c_out    = 1'b0;
        bus.alu_op   = AluAdd;
        bus.run      = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        case (state_q)
            StRst: state_d = StT0;
            StT0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
                state_d    = StT1;
            end
            StT1: begin
                bus.zlow_out = 1'b1;
                bus.pc_in    = ~t1_wait_q;
                bus.read     = 1'b1;
                bus.mdr_in   = 1'b1;
                if (bus.mem_done) state_d = StT2;
            end
            StT2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
                state_d     = StT3;
            end
            StT3: begin
                if (op.alu || op.imm) begin
                    bus.gr    = GrB;
                    bus.r_out = 1'b1;
                    bus.y_in  = 1'b1;
                    state_d   = StT4;
                end else if (op.ld || op.st) begin
                    bus.gr     = GrB;
                    bus.ba_out = 1'b1;
                    bus.y_in   = 1'b1;
                    state_d    = StT4;
                end else if (op.halt) begin
                    state_d = StHalt;
                end else begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d   = StHalt;
                    illegal_d = 1'b1;
`else
                    state_d = StT0;
`endif
                end
            end
            StT4: begin
                state_d = StT0;
                if (op.alu) begin
                    bus.gr     = GrC;
                    bus.r_out  = 1'b1;
                    bus.z_in   = 1'b1;
                    bus.alu_op = alu_op_dec;
                    state_d    = StT5;
                end else if (op.imm || op.ld || op.st) begin
                    bus.c_out = 1'b1;
                    bus.z_in  = 1'b1;
                    state_d   = StT5;
                end
            end
            StT5: begin
                bus.zlow_out = 1'b1;
                state_d      = StT0;
                if (op.ld || op.st) begin
                    bus.mar_in = 1'b1;
                    state_d    = StT6;
                end else begin
                    bus.gr   = GrA;
                    bus.r_in = 1'b1;
                end
            end
            StT6: begin
                state_d = StT0;
                if (op.ld) begin
                    bus.read   = 1'b1;
                    bus.mdr_in = 1'b1;
                    state_d    = bus.mem_done ? StT7 : StT6;
                end else if (op.st) begin
                    bus.gr     = GrA;
                    bus.r_out  = 1'b1;
                    bus.mdr_in = 1'b1;
                    state_d    = StT7;
                end
            end
            StT7: begin
                state_d = StT0;
                if (op.ld) begin
                    bus.mdr_out = 1'b1;
                    bus.gr      = GrA;
                    bus.r_in    = 1'b1;
                end else if (op.st) begin
                    bus.write = 1'b1;
                    state_d   = bus.mem_done ? StT0 : StT7;
                end
            end
            StHalt: bus.run = 1'b0;
            default: state_d = StRst;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer. Each instruction is
// expanded into its per-cycle list of expected strobes; the stimulus pushes one
// expectation per cycle and a negedge monitor pops and compares.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic clear = 1'b1;

    cu_if bus ();

    control_sequencer u_dut (
        .clock_i (clk),
        .clear_i (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write;
        logic       ir_in, y_in, z_in, zlow_out;
        logic [2:0] gr;
        logic       r_in, r_out, ba_out, c_out;
        logic [1:0] alu_op;
        logic       run, illegal;
    } outs_t;

    outs_t       exp_q[$];
    outs_t       mon_e, mon_a;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cur_ir = '0;

`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    function automatic outs_t idle();
        outs_t o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.pc_out = bus.pc_out;   o.pc_in = bus.pc_in;     o.inc_pc = bus.inc_pc;
        o.mar_in = bus.mar_in;   o.mdr_in = bus.mdr_in;   o.mdr_out = bus.mdr_out;
        o.read = bus.read;       o.write = bus.write;     o.ir_in = bus.ir_in;
        o.y_in = bus.y_in;       o.z_in = bus.z_in;       o.zlow_out = bus.zlow_out;
        o.gr = bus.gr;           o.r_in = bus.r_in;       o.r_out = bus.r_out;
        o.ba_out = bus.ba_out;   o.c_out = bus.c_out;     o.alu_op = bus.alu_op;
        o.run = bus.run;         o.illegal = bus.illegal;
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = sample();
            n_checks++;
            if (mon_a !== mon_e) begin
                n_errors++;
                $display("FAIL strobes t=%0t ir=%h actual=%h required=%h",
                         $time, cur_ir, mon_a, mon_e);
            end
        end
    end

    // One cycle: expect o during this cycle, drive inputs that decide the next state.
    task automatic step(input outs_t o, input logic md, input logic clr);
        exp_q.push_back(o);
        bus.ir       = cur_ir;
        bus.mem_done = md;
        clear        = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step_any(input outs_t o);
        step(o, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Memory wait: lat cycles without completion, then one with MemDone.
    task automatic wait_step(input outs_t first, input outs_t rest, input int lat);
        for (int i = 0; i <= lat; i++) step((i == 0) ? first : rest, (i == lat), 1'b0);
    endtask

    task automatic halted(input logic ill);
        outs_t o = '0;
        o.illegal = ill;
        repeat (20) step_any(o);
        step(o, 1'($urandom_range(0, 1)), 1'b1);
        step_any(idle());
    endtask

    // kind: 0 alu, 1 addi, 2 ld, 3 st, 4 halt, 5 undefined
    task automatic run_instr(input logic [31:0] ir, input int lf, input int lm, input bit clr_f);
        outs_t o, t1f, t1r;
        int kind;
        logic [1:0] aop;
        cur_ir = ir;
        aop = 2'b00;
        case (ir[31:27])
            5'b00011: kind = 0;
            5'b00100: begin kind = 0; aop = 2'b01; end
            5'b00101: begin kind = 0; aop = 2'b10; end
            5'b00110: begin kind = 0; aop = 2'b11; end
            5'b01100: kind = 1;
            5'b00000: kind = 2;
            5'b00010: kind = 3;
            5'b11011: kind = 4;
            default:  kind = 5;
        endcase
        o = idle(); o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
        step_any(o);
        t1r = idle(); t1r.zlow_out = 1; t1r.read = 1; t1r.mdr_in = 1;
        t1f = t1r; t1f.pc_in = 1;
        if (clr_f) begin
            step(t1f, 1'b0, 1'b0);
            step(t1r, 1'b0, 1'b1);
            step_any(idle());
            return;
        end
        wait_step(t1f, t1r, lf);
        o = idle(); o.mdr_out = 1; o.ir_in = 1;
        step_any(o);
        o = idle();
        if (kind <= 1) begin o.gr = 3'b010; o.r_out = 1; o.y_in = 1; end
        if (kind == 2 || kind == 3) begin o.gr = 3'b010; o.ba_out = 1; o.y_in = 1; end
        step_any(o);
        if (kind == 4) begin halted(1'b0); return; end
        if (kind == 5) begin
            if (Trap) halted(1'b1);
            return;
        end
        o = idle(); o.z_in = 1;
        if (kind == 0) begin o.gr = 3'b100; o.r_out = 1; o.alu_op = aop; end
        else o.c_out = 1;
        step_any(o);
        o = idle(); o.zlow_out = 1;
        if (kind <= 1) begin o.gr = 3'b001; o.r_in = 1; end
        else o.mar_in = 1;
        step_any(o);
        if (kind == 2) begin
            o = idle(); o.read = 1; o.mdr_in = 1;
            wait_step(o, o, lm);
            o = idle(); o.mdr_out = 1; o.gr = 3'b001; o.r_in = 1;
            step_any(o);
        end else if (kind == 3) begin
            o = idle(); o.gr = 3'b001; o.r_out = 1; o.mdr_in = 1;
            step_any(o);
            o = idle(); o.write = 1;
            wait_step(o, o, lm);
        end
    endtask

    logic [4:0] ops [10] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
                             5'b00000, 5'b00010, 5'b11011, 5'b11111, 5'b00001};

    initial begin
        bus.ir       = '0;
        bus.mem_done = 1'b0;
        @(posedge clk);
        #1;
        step_any(idle());
        run_instr(32'h1891_8000, 0, 0, 0);
        run_instr({5'b00000, 4'd4, 4'd2, 19'h10}, 1, 3, 0);
        run_instr({5'b00010, 4'd5, 4'd3, 19'h7ffff}, 2, 0, 0);
        run_instr({5'b11011, 27'd0}, 0, 0, 0);
        run_instr(32'h1891_8000, 0, 0, 1);
        run_instr({5'b00100, 27'h123_4567}, 3, 0, 0);
        run_instr({5'b11111, 27'd0}, 0, 0, 0);
        run_instr({5'b01100, 27'h0ab_cdef}, 0, 0, 0);
        for (int n = 0; n < 80; n++) begin
            run_instr({ops[$urandom_range(0, 9)], 27'($urandom)}, $urandom_range(0, 3),
                      $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
